// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the shared datapath/memory.
// The datapath side (master) drives opcode and mem_ready; the controller (slave) drives the selects and enables.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [3:0] state;
    logic       illegal_op;
    logic       mem_err;

    modport master (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, state,
               illegal_op, mem_err
    );

    modport slave (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, state,
               illegal_op, mem_err
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore main control FSM for the multicycle MIPS datapath, with memory-wait timeout and opcode trap.
// Define MULTICYCLE_ADDI_EN to build the ADDI path (ADDIEX/ADDIWB); otherwise opcode 8 traps to HALT.
//
// state  | meaning
// START  | one idle cycle after reset
// FETCH  | read instruction, PC += 4 on mem_ready
// DECODE | register read, precompute branch target
// MEMADR | load/store address calculation
// MEMRD  | data memory read
// MEMWB  | load result to register file
// MEMWR  | data memory write
// EXEC   | R-type ALU operation
// RWB    | R-type result to register file
// BRANCH | BEQ compare and conditional PC update
// JUMP   | PC <= jump target
// ADDIEX | ADDI ALU operation
// ADDIWB | ADDI result to register file
// HALT   | unimplemented opcode, held until reset
module multicycle_control #(
    parameter int WAIT_LIMIT = 8
) (
    input logic                clk,
    input logic                reset_n,
    multicycle_control_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        HALT   = 4'd12,
        START  = 4'd13
    } state_e;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_LIMIT);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_wait;
    state_e     ready_st;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= START;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wait_d          = 8'd0;
        mem_wait        = 1'b0;
        ready_st        = FETCH;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUOp       = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.PCSource    = 2'b00;
        bus.mem_err     = 1'b0;

        case (state_q)
            START: state_d = FETCH;
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                mem_wait    = 1'b1;
                ready_st    = DECODE;
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    6'd0:        state_d = EXEC;
                    6'd35, 6'd43: state_d = MEMADR;
                    6'd4:        state_d = BRANCH;
                    6'd2:        state_d = JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    6'd8:        state_d = ADDIEX;
`else
                    6'd8:        state_d = HALT;
`endif
                    default:     state_d = HALT;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                if (bus.opcode == 6'd35)      state_d = MEMRD;
                else if (bus.opcode == 6'd43) state_d = MEMWR;
                else                          state_d = HALT;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                mem_wait    = 1'b1;
                ready_st    = MEMWB;
            end
            MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                mem_wait     = 1'b1;
                ready_st     = FETCH;
            end
            EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
                state_d     = RWB;
            end
            RWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
                state_d      = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                state_d         = FETCH;
            end
            JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                state_d      = FETCH;
            end
`ifdef MULTICYCLE_ADDI_EN
            ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = ADDIWB;
            end
            ADDIWB: begin
                bus.RegWrite = 1'b1;
                state_d      = FETCH;
            end
`endif
            HALT:    state_d = HALT;
            default: state_d = START;
        endcase

        // A completed access beats a timeout landing in the same cycle; wait_d's default of 0 clears on every exit.
        if (mem_wait) begin
            if (bus.mem_ready) begin
                state_d = ready_st;
            end else if (wait_q == WAIT_LIM) begin
                bus.mem_err = 1'b1;
                state_d     = FETCH;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
    end

    assign bus.state      = state_q;
    assign bus.illegal_op = (state_q == HALT);
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle reference model plus directed instruction sequences.
module tb_multicycle_control;
    localparam int WL = 3;

    localparam int B_PCW  = 21;
    localparam int B_PCWC = 20;
    localparam int B_IORD = 19;
    localparam int B_MRD  = 18;
    localparam int B_MWR  = 17;
    localparam int B_MTR  = 16;
    localparam int B_RW   = 13;
    localparam int B_RDST = 12;
    localparam int B_ILL  = 1;
    localparam int B_ERR  = 0;
    localparam logic [21:0] RESET_WORD = 22'h000034;

    logic clk;
    logic reset_n;
    multicycle_control_if bus();

    multicycle_control #(.WAIT_LIMIT(WL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [21:0] dut_word;
    assign dut_word = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                       bus.MemtoReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                       bus.ALUOp, bus.ALUSrcB, bus.PCSource, bus.state, bus.illegal_op,
                       bus.mem_err};

    // Reference: control word for a given step, written straight from the per-state output list.
    function automatic logic [21:0] model_out(int s, logic rdy, int w);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, mtr = 0, irw = 0, asa = 0;
        logic rw = 0, rdst = 0, ill = 0, err;
        int aluop = 0, alub = 0, pcs = 0;
        bit waits = (s == 0) || (s == 3) || (s == 5);
        err = waits && !rdy && (w == WL);
        case (s)
            0:  begin mrd = 1; alub = 1; pcw = rdy; irw = rdy; end
            1:  alub = 3;
            2:  begin asa = 1; alub = 2; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin mtr = 1; rw = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aluop = 2; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin asa = 1; aluop = 1; pcwc = 1; pcs = 1; end
            9:  begin pcw = 1; pcs = 2; end
`ifdef MULTICYCLE_ADDI_EN
            10: begin asa = 1; alub = 2; end
            11: rw = 1;
`endif
            12: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, mtr, irw, asa, rw, rdst,
                2'(aluop), 2'(alub), 2'(pcs), 4'(s), ill, err};
    endfunction

    int m_state = 13;
    int m_wait  = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 13;
            m_wait  = 0;
        end else begin
            int nxt;
            logic rdy;
            rdy = bus.mem_ready;
            nxt = m_state;
            case (m_state)
                13: nxt = 0;
                1: begin
                    if (bus.opcode == 0) nxt = 6;
                    else if (bus.opcode == 35 || bus.opcode == 43) nxt = 2;
                    else if (bus.opcode == 4) nxt = 8;
                    else if (bus.opcode == 2) nxt = 9;
`ifdef MULTICYCLE_ADDI_EN
                    else if (bus.opcode == 8) nxt = 10;
`endif
                    else nxt = 12;
                end
                2:  nxt = (bus.opcode == 35) ? 3 : (bus.opcode == 43) ? 5 : 12;
                4, 7, 8, 9, 11: nxt = 0;
                6:  nxt = 7;
                10: nxt = 11;
                12: nxt = 12;
                default: ;
            endcase
            if (m_state == 0 || m_state == 3 || m_state == 5) begin
                if (rdy) begin
                    nxt = (m_state == 0) ? 1 : (m_state == 3) ? 4 : 0;
                    m_wait = 0;
                end else if (m_wait == WL) begin
                    nxt = 0;
                    m_wait = 0;
                end else begin
                    m_wait = m_wait + 1;
                end
            end else begin
                m_wait = 0;
            end
            m_state = nxt;
        end
    end

    task automatic check(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_w(string name, logic [21:0] act, logic [21:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) check_w("cycle", dut_word, model_out(m_state, bus.mem_ready, m_wait));

    int          st_q[$];
    int          mq[$];
    logic [21:0] w_q[$];
    int          exp_q[$];

    always @(negedge clk) begin
        st_q.push_back(int'(bus.state));
        mq.push_back(m_state);
        w_q.push_back(dut_word);
    end

    task automatic clear_trace();
        st_q.delete();
        mq.delete();
        w_q.delete();
    endtask

    task automatic drive(logic rdy, logic [5:0] op);
        @(posedge clk);
        #2;
        bus.mem_ready = rdy;
        bus.opcode    = op;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_seq(string name);
        check({name, "_len"}, st_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < st_q.size(); i++) begin
            check($sformatf("%s_state%0d", name, i), st_q[i], exp_q[i]);
            check($sformatf("%s_model%0d", name, i), mq[i], exp_q[i]);
        end
    endtask

    function automatic int count_bit(int pos);
        int n = 0;
        foreach (w_q[i]) if (w_q[i][pos]) n++;
        return n;
    endfunction

    function automatic int count_state(int s);
        int n = 0;
        foreach (st_q[i]) if (st_q[i] == s) n++;
        return n;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n       = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'd0;
        repeat (3) @(posedge clk);
        settle();
        check_w("reset_word", dut_word, RESET_WORD);

        // R-type with zero-wait memory
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        clear_trace();
        repeat (5) drive(1'b1, 6'd0);
        settle();
        exp_q = '{13, 0, 1, 6, 7, 0};
        check_seq("rtype");
        check("rtype_regwrite_cnt", count_bit(B_RW), 1);
        check("rtype_regwrite_rwb", int'(w_q[4][B_RW]), 1);
        check("rtype_regdst_rwb", int'(w_q[4][B_RDST]), 1);
        check("rtype_pcwrite_cnt", count_bit(B_PCW), 2);
        check("rtype_pcwrite_fetch", int'(w_q[1][B_PCW]), 1);

        // LW with two not-ready cycles in MEMRD
        bus.opcode = 6'd35;
        clear_trace();
        drive(1'b1, 6'd35);
        drive(1'b1, 6'd35);
        drive(1'b0, 6'd35);
        drive(1'b0, 6'd35);
        drive(1'b1, 6'd35);
        drive(1'b1, 6'd35);
        drive(1'b1, 6'd4);
        settle();
        exp_q = '{1, 2, 3, 3, 3, 4, 0};
        check_seq("lw");
        n = 0;
        foreach (w_q[i]) if (w_q[i][B_MRD] && w_q[i][B_IORD]) n++;
        check("lw_memread_iord_cycles", n, 3);
        check("lw_memtoreg_memwb", int'(w_q[5][B_MTR]), 1);

        // BEQ then J
        clear_trace();
        drive(1'b1, 6'd4);
        drive(1'b1, 6'd4);
        drive(1'b1, 6'd2);
        drive(1'b1, 6'd2);
        drive(1'b1, 6'd2);
        drive(1'b1, 6'd43);
        settle();
        exp_q = '{1, 8, 0, 1, 9, 0};
        check_seq("beq_j");
        check("beq_pcwritecond_cnt", count_bit(B_PCWC), 1);
        check("beq_aluop", int'(w_q[1][11:10]), 1);
        check("beq_pcsource", int'(w_q[1][7:6]), 1);
        check("j_pcwrite", int'(w_q[4][B_PCW]), 1);
        check("j_pcsource", int'(w_q[4][7:6]), 2);

        // SW: timeout on the 4th not-ready MEMWR cycle
        clear_trace();
        drive(1'b1, 6'd43);
        drive(1'b1, 6'd43);
        repeat (4) drive(1'b0, 6'd43);
        drive(1'b1, 6'd43);
        settle();
        exp_q = '{1, 2, 5, 5, 5, 5, 0};
        check_seq("sw_timeout");
        check("sw_timeout_err_cnt", count_bit(B_ERR), 1);
        check("sw_timeout_err_4th", int'(w_q[5][B_ERR]), 1);

        // SW: mem_ready arrives exactly at the limit
        clear_trace();
        drive(1'b1, 6'd43);
        drive(1'b1, 6'd43);
        repeat (3) drive(1'b0, 6'd43);
        drive(1'b1, 6'd43);
        drive(1'b0, 6'd8);
        settle();
        exp_q = '{1, 2, 5, 5, 5, 5, 0};
        check_seq("sw_ready_at_limit");
        check("sw_ready_err_cnt", count_bit(B_ERR), 0);
        check("sw_memwrite_cnt", count_bit(B_MWR), 4);

        // Fetch timeout retries, then opcode 8
        clear_trace();
        repeat (3) drive(1'b0, 6'd8);
        drive(1'b1, 6'd8);
        drive(1'b1, 6'd8);
        drive(1'b1, 6'd8);
        settle();
`ifdef MULTICYCLE_ADDI_EN
        exp_q = '{0, 0, 0, 0, 1, 10};
`else
        exp_q = '{0, 0, 0, 0, 1, 12};
`endif
        check_seq("fetch_timeout_op8");
        check("fetch_timeout_err", int'(w_q[2][B_ERR]), 1);
        check("fetch_timeout_pcwrite_cnt", count_bit(B_PCW), 1);
        check("fetch_retry_pcwrite", int'(w_q[3][B_PCW]), 1);
`ifdef MULTICYCLE_ADDI_EN
        clear_trace();
        drive(1'b1, 6'd8);
        drive(1'b1, 6'd63);
        drive(1'b1, 6'd63);
        settle();
        exp_q = '{11, 0, 1};
        check_seq("addi_tail");
`endif

        // HALT holds regardless of inputs
        clear_trace();
        for (int i = 0; i < 20; i++) drive(1'(i % 2), 6'(i));
        settle();
        check("halt_cycles", count_state(12), 20);
        check("halt_illegal_cnt", count_bit(B_ILL), 20);
        #2;
        reset_n = 1'b0;
        #1;
        check_w("halt_async_reset", dut_word, RESET_WORD);

        // Reset pulse during a MEMRD wait
        @(posedge clk);
        #2;
        reset_n       = 1'b1;
        bus.opcode    = 6'd35;
        bus.mem_ready = 1'b1;
        drive(1'b1, 6'd35);
        drive(1'b1, 6'd35);
        drive(1'b1, 6'd35);
        drive(1'b0, 6'd35);
        drive(1'b0, 6'd35);
        check("pre_reset_state", int'(bus.state), 3);
        #1;
        reset_n = 1'b0;
        #1;
        check_w("memrd_async_reset", dut_word, RESET_WORD);
        @(posedge clk);
        #2;
        reset_n       = 1'b1;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b1;
        clear_trace();
        repeat (5) drive(1'b1, 6'd0);
        settle();
        exp_q = '{13, 0, 1, 6, 7, 0};
        check_seq("post_reset_fetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style main control FSM that sequences the shared multicycle MIPS datapath: one memory port for instructions and data, one ALU for PC increment, branch target and execution. It replaces the single-cycle opcode decoder. It walks each instruction through fetch, decode, execute, memory and write-back, and drives every mux select and write enable per step. It stalls on a memory ready handshake, and traps unimplemented opcodes.

## Interface
- `WAIT_LIMIT`, default 8: number of consecutive not-ready cycles a memory access may wait before it is aborted (legal range 1..255).
- `clk` in 1: single system clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `opcode` in 6: bits [31:26] of the instruction register. Valid from the DECODE state until the next IRWrite.
- `mem_ready` in 1: memory has completed the current read or write in this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`: each out 1, datapath controls.
- `ALUOp` out 2: 00 add, 01 subtract, 10 use funct field.
- `ALUSrcB` out 2: 00 reg B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- `PCSource` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `state` out 4: current state encoding, for debug.
- `illegal_op` out 1: high while trapped.
- `mem_err` out 1: one-cycle pulse on memory timeout.

## Operation
- State encodings: START=13, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=12.
- Every output defaults to 0 and is set only in the states listed below.
- START: all outputs 0. Always goes to FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=1 and PCWrite=1 only in a cycle with mem_ready=1 (Mealy gating). Moves to DECODE on mem_ready, otherwise stays.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 0 → EXEC
  - 35 or 43 → MEMADR
  - 4 → BRANCH
  - 2 → JUMP
  - 8 → ADDIEX (only when the Configuration macro is defined)
  - anything else → HALT
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for opcode 35, MEMWR for opcode 43.
- MEMRD: MemRead=1, IorD=1. Goes to MEMWB on mem_ready.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Goes to FETCH on mem_ready.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- HALT: illegal_op=1, all other outputs 0. Stays in HALT until reset.
- Wait counter (8 bits):
  - Clears on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle in those states while mem_ready=0.
  - When the count equals WAIT_LIMIT and mem_ready is still 0, that cycle drives mem_err=1 and the next state is FETCH. A timed-out fetch therefore retries, with PC unchanged, and a timed-out LW skips its write-back.
  - If mem_ready=1 arrives in the same cycle as the limit, mem_ready wins: the access completes normally and no mem_err is raised.

## Timing
- Cycles per instruction with zero-wait memory: R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4. Each not-ready cycle in FETCH, MEMRD or MEMWR adds 1.
- State advances on the rising edge of clk. Outputs are a function of registered state, except IRWrite, PCWrite and mem_err, which are additionally gated combinationally by mem_ready.
- Reset:
  - Asserting reset_n low at any time, including mid-instruction or mid-wait, immediately forces state=START, clears the wait counter and clears illegal_op. All outputs are 0 while reset is held.
  - The first FETCH occurs in the second rising edge after deassertion: one cycle in START, then FETCH.
- opcode is sampled only in DECODE and MEMADR. Changes at any other time have no effect.

## Configuration
- `MULTICYCLE_ADDI_EN` defined: opcode 8 follows DECODE→ADDIEX→ADDIWB→FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
- Undefined: ADDIEX and ADDIWB are not built, and opcode 8 traps to HALT like any other unimplemented opcode.

## Test plan
- Reset, then opcode=0 with mem_ready=1 held → state sequence 13,0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. PCWrite=1 only in FETCH.
- opcode=35 with mem_ready low for 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 for exactly 3 cycles. MemtoReg=1 in MEMWB.
- opcode=4, then opcode=2 → BRANCH drives PCWriteCond=1, ALUOp=01, PCSource=01 for one cycle. JUMP drives PCWrite=1, PCSource=10. Each instruction takes 3 cycles.
- WAIT_LIMIT=3 with mem_ready=0 in MEMWR → mem_err pulses on the 4th MEMWR cycle and the next state is FETCH. The same test with mem_ready=1 on that 4th cycle → no mem_err.
- opcode=8 → with MULTICYCLE_ADDI_EN: sequence 1,10,11,0. Without it: state 12, illegal_op=1 for 20 cycles, then reset_n low clears it asynchronously.
- reset_n pulsed low during MEMRD wait → state=13 and all outputs 0 within the same cycle, then a clean fetch.
